wb_timer: RTL

- 16-bit down-counting timer; a responder on the d16 CPU data bus, alongside blkmem and uart.
- Selected by one syscon slaveselect line on i_cyc.
- Provides periodic or one-shot interrupts to the CPU i_int input, which is currently unconnected.
- Register file is read combinationally; writes are zero-wait-state, matching the other slaves.

---
 rtl/wb_timer_pkg.sv | 24 ++
 rtl/wb_timer_if.sv | 25 ++
 rtl/wb_timer_prescaler.sv | 44 ++++
 rtl/wb_timer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/wb_timer_pkg.sv
// d16 timer shared definitions: register addresses, CTRL/STATUS bit positions
// and the run/idle state encoding.
package d16_timer_pkg;

   localparam logic [2:0] ADDR_CTRL   = 3'd0;
   localparam logic [2:0] ADDR_LOAD   = 3'd1;
   localparam logic [2:0] ADDR_COUNT  = 3'd2;
   localparam logic [2:0] ADDR_STATUS = 3'd3;
   localparam logic [2:0] ADDR_CMP    = 3'd4;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_RELOAD  = 1;
   localparam int CTRL_IE      = 2;
   localparam int CTRL_PRE_LSB = 8;

   localparam int STATUS_EXP = 0;

   // RUN is exactly "CTRL.EN is set"; the state register is the EN bit.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } timer_state_e;

endpackage

// File: rtl/wb_timer_if.sv
// d16 CPU data bus as seen by one responder: write data, read data, register
// select, write enable and the syscon slave select.
interface wb_timer_if;
   logic [15:0] i_dat;
   logic [15:0] o_dat;
   logic [2:0]  i_addr;
   logic        i_we;
   logic        i_cyc;

   modport slave (
      input  i_dat,
      input  i_addr,
      input  i_we,
      input  i_cyc,
      output o_dat
   );

   modport master (
      output i_dat,
      output i_addr,
      output i_we,
      output i_cyc,
      input  o_dat
   );
endinterface

// File: rtl/wb_timer_prescaler.sv
// Clock prescaler for the d16 timer: emits a one-cycle tick every
// (divide+1) enabled cycles. Counter is held at 0 while disabled and
// cleared by 'clear' (any CTRL write).
module timer_prescaler #(
   parameter int PRESCALE_W = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [PRESCALE_W-1:0] divide,
   output logic                  tick
);

   localparam logic [PRESCALE_W-1:0] ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

   logic [PRESCALE_W-1:0] cnt_q;
   logic [PRESCALE_W-1:0] cnt_d;

   // Tick is decoded from the registered count, so it is never bus-combinational.
   assign tick = enable & (cnt_q == divide);

   // Next count: held/cleared to 0, wrap on tick, otherwise increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clear || !enable) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + ONE;
      end
   end

   // Prescaler count register.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_timer.sv
// wb_timer: 16-bit down-counting timer on the d16 CPU bus with periodic or
// one-shot level interrupt. Registers are read combinationally and written
// with zero wait states. Optional PWM output/CMP register when TIMER_PWM_EN
// is defined; without it o_pwm is tied low and address 4 reads 0.
// PRESCALE_W must not exceed 8 (PRE lives in CTRL[15:8]).
module wb_timer
   import d16_timer_pkg::*;
#(
   parameter int          PRESCALE_W = 8,
   parameter logic [15:0] RESET_LOAD = 16'hFFFF
) (
   input  logic       i_clk,
   input  logic       i_reset,
   wb_timer_if.slave  bus,
   output logic       o_int,
   output logic       o_pwm
);

   timer_state_e          state_q, state_d;
   logic                  reload_q, reload_d;
   logic                  ie_q, ie_d;
   logic                  exp_q, exp_d;
   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic [15:0]           load_q, load_d;
   logic [15:0]           count_q, count_d;

   logic        run;
   logic        tick;
   logic        wr;
   logic        wr_ctrl, wr_load, wr_count, wr_status;
   logic [15:0] ctrl_rd;

   assign run       = (state_q == ST_RUN);
   assign wr        = bus.i_cyc & bus.i_we;
   assign wr_ctrl   = wr & (bus.i_addr == ADDR_CTRL);
   assign wr_load   = wr & (bus.i_addr == ADDR_LOAD);
   assign wr_count  = wr & (bus.i_addr == ADDR_COUNT);
   assign wr_status = wr & (bus.i_addr == ADDR_STATUS);

   timer_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .enable  (run),
      .clear   (wr_ctrl),
      .divide  (pre_q),
      .tick    (tick)
   );

   // Next state: status clear, then tick effects, then bus writes override
   // so that writes win over the countdown while expiry still sets EXP.
   always_comb begin
      state_d  = state_q;
      reload_d = reload_q;
      ie_d     = ie_q;
      exp_d    = exp_q;
      pre_d    = pre_q;
      load_d   = load_q;
      count_d  = count_q;

      if (wr_status && bus.i_dat[STATUS_EXP]) begin
         exp_d = 1'b0;
      end

      if (tick) begin
         if (count_q != 16'd0) begin
            count_d = count_q - 16'd1;
         end else begin
            exp_d = 1'b1;
            if (reload_q) begin
               count_d = load_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
      end

      if (wr_ctrl) begin
         state_d  = bus.i_dat[CTRL_EN] ? ST_RUN : ST_IDLE;
         reload_d = bus.i_dat[CTRL_RELOAD];
         ie_d     = bus.i_dat[CTRL_IE];
         pre_d    = bus.i_dat[CTRL_PRE_LSB +: PRESCALE_W];
      end
      if (wr_load) begin
         load_d = bus.i_dat;
      end
      if (wr_count) begin
         count_d = bus.i_dat;
      end
   end

   // Timer register file and run/idle state.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= ST_IDLE;
         reload_q <= 1'b0;
         ie_q     <= 1'b0;
         exp_q    <= 1'b0;
         pre_q    <= '0;
         load_q   <= RESET_LOAD;
         count_q  <= 16'd0;
      end else begin
         state_q  <= state_d;
         reload_q <= reload_d;
         ie_q     <= ie_d;
         exp_q    <= exp_d;
         pre_q    <= pre_d;
         load_q   <= load_d;
         count_q  <= count_d;
      end
   end

   // Interrupt is a function of flops only.
   assign o_int = exp_q & ie_q;

`ifdef TIMER_PWM_EN
   logic [15:0] cmp_q, cmp_d;
   logic        pwm_q, pwm_d;
   logic        wr_cmp;

   assign wr_cmp = wr & (bus.i_addr == ADDR_CMP);

   // CMP register update and PWM compare.
   always_comb begin
      cmp_d = wr_cmp ? bus.i_dat : cmp_q;
      pwm_d = run & (count_q < cmp_q);
   end

   // PWM compare register and registered output.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cmp_q <= 16'd0;
         pwm_q <= 1'b0;
      end else begin
         cmp_q <= cmp_d;
         pwm_q <= pwm_d;
      end
   end

   assign o_pwm = pwm_q;
`else
   assign o_pwm = 1'b0;
`endif

   // CTRL read image; PRE bits beyond PRESCALE_W read as 0.
   always_comb begin
      ctrl_rd                              = 16'd0;
      ctrl_rd[CTRL_EN]                     = run;
      ctrl_rd[CTRL_RELOAD]                 = reload_q;
      ctrl_rd[CTRL_IE]                     = ie_q;
      ctrl_rd[CTRL_PRE_LSB +: PRESCALE_W]  = pre_q;
   end

   // Combinational read mux, zero when not selected.
   always_comb begin
      bus.o_dat = 16'd0;
      if (bus.i_cyc) begin
         case (bus.i_addr)
            ADDR_CTRL:   bus.o_dat = ctrl_rd;
            ADDR_LOAD:   bus.o_dat = load_q;
            ADDR_COUNT:  bus.o_dat = count_q;
            ADDR_STATUS: bus.o_dat = {15'd0, exp_q};
`ifdef TIMER_PWM_EN
            ADDR_CMP:    bus.o_dat = cmp_q;
`endif
            default:     bus.o_dat = 16'd0;
         endcase
      end
   end

endmodule
